// File: rtl/sys_host_pkg.sv
// Shared types and frame constants for the host-side UART command initiator.
package sys_host_pkg;

    typedef enum logic [1:0] {
        WRITE   = 2'd0,
        READ    = 2'd1,
        ALU_OP  = 2'd2,
        ALU_NOP = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2
    } host_state_t;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    function automatic logic [2:0] frame_len(input cmd_t c);
        logic [2:0] n;
        unique case (c)
            WRITE:   n = 3'd3;
            READ:    n = 3'd2;
            ALU_OP:  n = 3'd4;
            ALU_NOP: n = 3'd2;
            default: n = 3'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sys_host_master.sv
// Host command initiator: serializes one request into UART frame bytes
// and collects the single response byte with a timeout.
module sys_host_master
    import sys_host_pkg::*;
#(
    parameter int FRAME_DATA  = 8,
    parameter int ADDR_BITS   = 4,
    parameter int FUN_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [1:0]            req_cmd,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [FRAME_DATA-1:0] req_data,
    input  logic [FRAME_DATA-1:0] req_op_a,
    input  logic [FRAME_DATA-1:0] req_op_b,
    input  logic [FUN_WIDTH-1:0]  req_fun,
    output logic [FRAME_DATA-1:0] tx_data,
    output logic                  tx_vld,
    input  logic                  tx_rdy,
    input  logic [FRAME_DATA-1:0] rx_data,
    input  logic                  rx_vld,
    output logic [FRAME_DATA-1:0] rsp_data,
    output logic                  rsp_vld,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    host_state_t           state;
    cmd_t                  cmd_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [FRAME_DATA-1:0] data_q;
    logic [FRAME_DATA-1:0] op_a_q;
    logic [FRAME_DATA-1:0] op_b_q;
    logic [FUN_WIDTH-1:0]  fun_q;
    logic [1:0]            idx;
    logic [1:0]            idx_nxt;
    logic [CW-1:0]         cnt;
    logic                  last;

    function automatic logic [FRAME_DATA-1:0] sel_byte(
        input cmd_t                  c,
        input logic [1:0]            i,
        input logic [ADDR_BITS-1:0]  a,
        input logic [FRAME_DATA-1:0] d,
        input logic [FRAME_DATA-1:0] oa,
        input logic [FRAME_DATA-1:0] ob,
        input logic [FUN_WIDTH-1:0]  f
    );
        logic [FRAME_DATA-1:0] b;
        b = '0;
        unique case (c)
            WRITE: begin
                case (i)
                    2'd0:    b = FRAME_DATA'(CMD_WR);
                    2'd1:    b = FRAME_DATA'(a);
                    default: b = d;
                endcase
            end
            READ: begin
                case (i)
                    2'd0:    b = FRAME_DATA'(CMD_RD);
                    default: b = FRAME_DATA'(a);
                endcase
            end
            ALU_OP: begin
                case (i)
                    2'd0:    b = FRAME_DATA'(CMD_ALU_OP);
                    2'd1:    b = oa;
                    2'd2:    b = ob;
                    default: b = FRAME_DATA'(f);
                endcase
            end
            default: begin
                case (i)
                    2'd0:    b = FRAME_DATA'(CMD_ALU_NOP);
                    default: b = FRAME_DATA'(f);
                endcase
            end
        endcase
        return b;
    endfunction

    assign req_rdy = (state == IDLE);
    assign busy    = (state != IDLE);
    assign idx_nxt = idx + 2'd1;
    assign last    = ({1'b0, idx} == frame_len(cmd_q) - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmd_q    <= WRITE;
            addr_q   <= '0;
            data_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            fun_q    <= '0;
            idx      <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_vld   <= 1'b0;
            rsp_data <= '0;
            rsp_vld  <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_vld <= 1'b0;
            rsp_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_vld) begin
                        cmd_q   <= cmd_t'(req_cmd);
                        addr_q  <= req_addr;
                        data_q  <= req_data;
                        op_a_q  <= req_op_a;
                        op_b_q  <= req_op_b;
                        fun_q   <= req_fun;
                        idx     <= '0;
                        tx_vld  <= 1'b1;
                        tx_data <= sel_byte(cmd_t'(req_cmd), 2'd0,
                                            req_addr, req_data,
                                            req_op_a, req_op_b, req_fun);
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_rdy) begin
                        if (last) begin
                            tx_vld <= 1'b0;
                            cnt    <= '0;
                            state  <= (cmd_q == WRITE) ? IDLE : WAIT_RSP;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= sel_byte(cmd_q, idx_nxt, addr_q,
                                                data_q, op_a_q, op_b_q,
                                                fun_q);
                        end
                    end
                end
                WAIT_RSP: begin
                    // Response data takes priority over a coincident expiry.
                    if (rx_vld) begin
                        rsp_data <= rx_data;
                        rsp_vld  <= 1'b1;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        rsp_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_host_master.sv
// Directed bench for sys_host_master: frame bytes, handshake holds,
// response capture, timeout, expiry collision and mid-frame reset.
module tb_sys_host_master;

    localparam int FD = 8;
    localparam int AB = 4;
    localparam int FW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic [1:0]    req_cmd = '0;
    logic [AB-1:0] req_addr = '0;
    logic [FD-1:0] req_data = '0;
    logic [FD-1:0] req_op_a = '0;
    logic [FD-1:0] req_op_b = '0;
    logic [FW-1:0] req_fun = '0;
    logic [FD-1:0] tx_data;
    logic          tx_vld;
    logic          tx_rdy = 1'b1;
    logic [FD-1:0] rx_data = '0;
    logic          rx_vld = 1'b0;
    logic [FD-1:0] rsp_data;
    logic          rsp_vld;
    logic          rsp_err;
    logic          busy;

    int total = 0;
    int bad = 0;
    int n_vld = 0;
    int n_err = 0;

    sys_host_master #(
        .FRAME_DATA (FD),
        .ADDR_BITS  (AB),
        .FUN_WIDTH  (FW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_cmd (req_cmd),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_op_a(req_op_a),
        .req_op_b(req_op_b),
        .req_fun (req_fun),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rsp_data(rsp_data),
        .rsp_vld (rsp_vld),
        .rsp_err (rsp_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsp_vld) n_vld++;
        if (rsp_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [AB-1:0] a,
                        input logic [FD-1:0] d, input logic [FD-1:0] oa,
                        input logic [FD-1:0] ob, input logic [FW-1:0] f);
        chk("rdy_before_req", {31'd0, req_rdy}, 32'd1);
        req_vld  = 1'b1;
        req_cmd  = c;
        req_addr = a;
        req_data = d;
        req_op_a = oa;
        req_op_b = ob;
        req_fun  = f;
        tick();
        req_vld  = 1'b0;
        req_cmd  = ~c;
        req_addr = '1;
        req_data = 8'h5A;
        req_op_a = 8'hA5;
        req_op_b = 8'h99;
        req_fun  = '1;
    endtask

    task automatic byte_is(input string tag, input logic [7:0] b);
        chk({tag, "_vld"}, {31'd0, tx_vld}, 32'd1);
        chk({tag, "_dat"}, {24'd0, tx_data}, {24'd0, b});
    endtask

    initial begin
        int v0, e0;
        #2;
        chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #12 rst = 1'b1;
        tick();
        chk("rdy_after_rst", {31'd0, req_rdy}, 32'd1);

        // WRITE addr=5 data=3C, tx_rdy tied high
        v0 = n_vld; e0 = n_err;
        tx_rdy = 1'b1;
        send(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        byte_is("wr_b0", 8'hAA);
        chk("wr_rdy_low", {31'd0, req_rdy}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        tick(); byte_is("wr_b1", 8'h05);
        tick(); byte_is("wr_b2", 8'h3C);
        tick();
        chk("wr_vld_off", {31'd0, tx_vld}, 32'd0);
        chk("wr_rdy_back", {31'd0, req_rdy}, 32'd1);
        chk("wr_no_rsp", n_vld - v0, 0);
        chk("wr_no_err", n_err - e0, 0);

        // READ addr=2 with tx_rdy stalls, rx_vld during SEND ignored
        v0 = n_vld;
        send(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        tx_rdy = 1'b0;
        byte_is("rd_b0", 8'hBB);
        tick(); byte_is("rd_b0_hold", 8'hBB);
        tx_rdy = 1'b1;
        tick(); byte_is("rd_b1", 8'h02);
        tx_rdy = 1'b0;
        tick(); byte_is("rd_b1_hold", 8'h02);
        tx_rdy = 1'b1;
        rx_vld = 1'b1; rx_data = 8'h55;
        tick();
        rx_vld = 1'b0;
        chk("rd_vld_off", {31'd0, tx_vld}, 32'd0);
        chk("rd_wait_busy", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        chk("rd_still_wait", {31'd0, busy}, 32'd1);
        rx_vld = 1'b1; rx_data = 8'h77;
        tick();
        rx_vld = 1'b0;
        chk("rd_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        chk("rd_rsp_data", {24'd0, rsp_data}, 32'h77);
        chk("rd_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("rd_pulse_1cyc", {31'd0, rsp_vld}, 32'd0);
        chk("rd_one_rsp", n_vld - v0, 1);

        // ALU_OP 14 + 0A fun 0
        send(2'd2, 4'h0, 8'h00, 8'h14, 8'h0A, 4'h0);
        byte_is("alu_b0", 8'hCC);
        tick(); byte_is("alu_b1", 8'h14);
        tick(); byte_is("alu_b2", 8'h0A);
        tick(); byte_is("alu_b3", 8'h00);
        tick();
        chk("alu_wait", {31'd0, busy}, 32'd1);
        rx_vld = 1'b1; rx_data = 8'h1E;
        tick();
        rx_vld = 1'b0;
        chk("alu_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        chk("alu_rsp_data", {24'd0, rsp_data}, 32'h1E);
        tick();

        // ALU_NOP fun 3
        send(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
        byte_is("nop_b0", 8'hDD);
        tick(); byte_is("nop_b1", 8'h03);
        tick();
        rx_vld = 1'b1; rx_data = 8'h42;
        tick();
        rx_vld = 1'b0;
        chk("nop_rsp_data", {24'd0, rsp_data}, 32'h42);
        tick();

        // READ timeout: error exactly TO cycles after WAIT_RSP entry
        v0 = n_vld; e0 = n_err;
        send(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        tick();
        tick();
        chk("to_entry", {31'd0, busy}, 32'd1);
        repeat (TO - 1) tick();
        chk("to_not_yet", {31'd0, rsp_err}, 32'd0);
        chk("to_busy_pre", {31'd0, busy}, 32'd1);
        tick();
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_no_vld", {31'd0, rsp_vld}, 32'd0);
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_data_kept", {24'd0, rsp_data}, 32'h42);
        tick();
        chk("to_err_1cyc", {31'd0, rsp_err}, 32'd0);
        chk("to_err_cnt", n_err - e0, 1);
        chk("to_vld_cnt", n_vld - v0, 0);

        // rx_vld on the expiry cycle: data wins
        e0 = n_err;
        send(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        tick();
        tick();
        repeat (TO - 1) tick();
        rx_vld = 1'b1; rx_data = 8'h99;
        tick();
        rx_vld = 1'b0;
        chk("col_vld", {31'd0, rsp_vld}, 32'd1);
        chk("col_err", {31'd0, rsp_err}, 32'd0);
        chk("col_data", {24'd0, rsp_data}, 32'h99);
        chk("col_err_cnt", n_err - e0, 0);
        tick();

        // rx_vld in IDLE is discarded
        v0 = n_vld;
        rx_vld = 1'b1; rx_data = 8'h11;
        tick();
        rx_vld = 1'b0;
        tick();
        chk("idle_rx_vld", n_vld - v0, 0);
        chk("idle_rx_data", {24'd0, rsp_data}, 32'h99);

        // reset during byte 2 of ALU_OP, then a clean WRITE
        send(2'd2, 4'h0, 8'h00, 8'h14, 8'h0A, 4'h5);
        tick();
        tick(); byte_is("rst_alu_b2", 8'h0A);
        rst = 1'b0;
        #1;
        chk("rst_mid_vld", {31'd0, tx_vld}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_data", {24'd0, tx_data}, 32'd0);
        #2 rst = 1'b1;
        tick();
        send(2'd0, 4'h9, 8'hC3, 8'h00, 8'h00, 4'h0);
        byte_is("rwr_b0", 8'hAA);
        tick(); byte_is("rwr_b1", 8'h09);
        tick(); byte_is("rwr_b2", 8'hC3);
        tick();
        chk("rwr_done", {31'd0, req_rdy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_host_master.md
Name: sys_host_master

Overview:
- Host-side command initiator for the UART register/ALU system.
- Takes one parallel command request and serializes it into the command frame bytes (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands) toward the UART transmitter.
- For read and ALU commands, waits for the single response byte from the UART receiver and returns it, with a timeout.
- Sits between a test/host controller and the host-side UART TX/RX byte interfaces.

Parameters:
- FRAME_DATA, 8, byte width of UART frames and response data.
- ADDR_BITS, 4, register-file address width; zero-extended into the address byte.
- FUN_WIDTH, 4, ALU function width; zero-extended into the function byte.
- TIMEOUT_CYC, 1024, clk cycles to wait for a response byte before flagging an error (must be >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_vld  in  1  command request valid.
- req_rdy  out  1  block can accept a request (high only in IDLE).
- req_cmd  in  2  command type: 0 = WRITE, 1 = READ, 2 = ALU_OP, 3 = ALU_NOP.
- req_addr  in  ADDR_BITS  register address (WRITE, READ).
- req_data  in  FRAME_DATA  write data (WRITE).
- req_op_a  in  FRAME_DATA  ALU operand A (ALU_OP).
- req_op_b  in  FRAME_DATA  ALU operand B (ALU_OP).
- req_fun  in  FUN_WIDTH  ALU function (ALU_OP, ALU_NOP).
- tx_data  out  FRAME_DATA  byte to the UART transmitter.
- tx_vld  out  1  tx_data valid.
- tx_rdy  in  1  UART transmitter accepts the byte.
- rx_data  in  FRAME_DATA  byte from the UART receiver.
- rx_vld  in  1  rx_data valid, single-cycle pulse.
- rsp_data  out  FRAME_DATA  response byte.
- rsp_vld  out  1  one-cycle pulse; rsp_data valid.
- rsp_err  out  1  one-cycle pulse; response timeout.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst = 0):
  - state = IDLE; byte index = 0; timeout counter = 0.
  - tx_data = 0, tx_vld = 0, rsp_data = 0, rsp_vld = 0, rsp_err = 0, busy = 0.
  - req_rdy = 1 once rst deasserts.
  - Reset mid-frame aborts the frame immediately; no partial-frame recovery.
- Request capture:
  - On req_vld && req_rdy (cycle N), all req_* fields are registered.
  - req_* are don't-care after capture.
- Frame bytes, in order:
  - WRITE: 0xAA, {0, addr}, data. 3 bytes, no response.
  - READ: 0xBB, {0, addr}. 2 bytes, 1 response byte.
  - ALU_OP: 0xCC, op_a, op_b, {0, fun}. 4 bytes, 1 response byte.
  - ALU_NOP: 0xDD, {0, fun}. 2 bytes, 1 response byte.
- States:
  - IDLE -> SEND on request accept.
  - SEND -> IDLE after the last byte of a WRITE.
  - SEND -> WAIT_RSP after the last byte of any other command.
  - WAIT_RSP -> IDLE on rx_vld or on timeout.
- SEND:
  - tx_vld and byte 0 are registered; both high from cycle N+1.
  - tx_data and tx_vld hold stable until tx_vld && tx_rdy.
  - On a handshake, the next byte is presented in the following cycle, so back-to-back handshakes are possible.
  - tx_vld deasserts the cycle after the last handshake.
- WAIT_RSP:
  - Timeout counter clears on entry and increments each cycle.
  - rx_vld: rsp_data <= rx_data and rsp_vld = 1 for one cycle, then IDLE.
  - Counter reaches TIMEOUT_CYC-1 without rx_vld: rsp_err = 1 for one cycle, rsp_data unchanged, then IDLE.
  - rx_vld in the same cycle as expiry: data wins; rsp_vld only, no rsp_err.
- rx_vld outside WAIT_RSP (IDLE, SEND) is discarded and has no effect.
- A WRITE produces neither rsp_vld nor rsp_err; completion is indicated by req_rdy returning high.
- req_rdy is low from the cycle after accept until back in IDLE.
- New requests are accepted the cycle after returning to IDLE.
- rsp_vld/rsp_err pulse in the same cycle state returns to IDLE.

Decomposition:
- Package sys_host_pkg:
  - cmd_t enum {WRITE, READ, ALU_OP, ALU_NOP}.
  - Opcode constants: CMD_WR = 8'hAA, CMD_RD = 8'hBB, CMD_ALU_OP = 8'hCC, CMD_ALU_NOP = 8'hDD.
  - host_state_t enum {IDLE, SEND, WAIT_RSP}.
  - Function returning frame length per cmd_t.
- No sub-module required.
  - Byte selection is a mux on (cmd, byte index).
  - The timeout counter is an inline $clog2(TIMEOUT_CYC)-bit counter.

Test Plan:
- WRITE addr=0x5, data=0x3C, tx_rdy tied 1 -> tx bytes AA, 05, 3C on three consecutive cycles starting N+1; no rsp_vld/rsp_err; req_rdy high again after the 3rd byte.
- READ addr=0x2, tx_rdy toggling 1-0-1, rx_vld with 0x77 five cycles after the last byte -> tx bytes BB, 02, each held through tx_rdy = 0; rsp_vld pulse with rsp_data = 0x77.
- ALU_OP a=0x14, b=0x0A, fun=0x0 -> tx bytes CC, 14, 0A, 00; rx 0x1E -> rsp_data = 0x1E; ALU_NOP fun=0x3 -> tx bytes DD, 03.
- READ with no rx_vld, TIMEOUT_CYC=16 -> rsp_err pulses exactly 16 cycles after WAIT_RSP entry; rsp_vld stays 0; return to IDLE.
- rx_vld on the exact expiry cycle -> rsp_vld = 1 and rsp_err = 0; rx_vld pulses during IDLE/SEND -> ignored, no rsp_vld.
- Assert rst during byte 2 of ALU_OP -> tx_vld = 0, busy = 0 immediately; next WRITE frame is emitted correctly from byte 0.
